// File: rtl/aw_tracker.sv
// -----------------------------------------------------------------------------
// aw_tracker
//
// Tracks a single outstanding AXI write transaction from one master to one of
// num_slaves slaves. The AW channel is routed by the 3-bit slave-select field
// m_awaddr[SEL_LSB+2:SEL_LSB]. The W channel is gated through w_open and steered
// by aw_sel_q. The B channel is returned only from the slave that took the AW.
// W beats are counted against the latched burst length. A mismatch with
// m_wlast produces a one-cycle wlast_err pulse.
//
// Optional feature: define AW_DECERR_EN to terminate unmapped addresses
// internally. In that case the AW is accepted with no s_awvalid, the W data is
// sunk (w_sink=1), and the master receives a DECERR (2'b11) response.
// Without the macro, unmapped addresses go to slave num_slaves-1.
//
// Handshake rule on every channel: a transfer occurs on a rising clk edge
// where valid and ready are both high. The valid side is never required to
// wait for ready before asserting.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   m_awaddr/len/valid   master AW request;  m_awready  master AW ready
//   s_awaddr/len         broadcast AW payload (num_slaves copies, flat)
//   s_awvalid/awready    per-slave AW handshake (one-hot valid)
//   m_wvalid/wready/wlast snooped master W handshake
//   w_open, w_sink       W path enable / decode-error W sink
//   aw_sel_q             latched slave index for the W router
//   s_bvalid/bresp       per-slave B response (bresp flat, 2 bits each)
//   s_bready             one-hot B ready
//   m_bvalid/bresp/bready master B channel
//   wlast_err            one-cycle pulse on burst-length mismatch
// -----------------------------------------------------------------------------
module aw_tracker #(
  parameter int num_slaves = 5,
  parameter int SEL_LSB    = 28
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [31:0]               m_awaddr,
  input  logic [7:0]                m_awlen,
  input  logic                      m_awvalid,
  output logic                      m_awready,
  output logic [num_slaves*32-1:0]  s_awaddr,
  output logic [num_slaves*8-1:0]   s_awlen,
  output logic [num_slaves-1:0]     s_awvalid,
  input  logic [num_slaves-1:0]     s_awready,
  input  logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic                      m_wlast,
  output logic                      w_open,
  output logic                      w_sink,
  output logic [2:0]                aw_sel_q,
  input  logic [num_slaves-1:0]     s_bvalid,
  input  logic [num_slaves*2-1:0]   s_bresp,
  output logic [num_slaves-1:0]     s_bready,
  output logic                      m_bvalid,
  output logic [1:0]                m_bresp,
  input  logic                      m_bready,
  output logic                      wlast_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    BRESP = 2'd2
  } state_t;

  localparam logic [3:0] NUM_SLAVES_4 = 4'(num_slaves);
  localparam logic [2:0] LAST_SEL     = 3'(num_slaves - 1);
  // Index recorded for an internally terminated transaction.
  localparam logic [2:0] DECERR_SEL   = 3'(num_slaves);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] sel;
  logic       mapped;
  logic [2:0] tgt_sel;
  logic       decerr_aw;
  logic       decerr_q;
  logic [7:0] beat_cnt;
  logic [7:0] awlen_q;
  logic       aw_hs;
  logic       w_beat;

  assign s_awaddr = {num_slaves{m_awaddr}};
  assign s_awlen  = {num_slaves{m_awlen}};

  assign sel    = m_awaddr[SEL_LSB+2:SEL_LSB];
  assign mapped = ({1'b0, sel} < NUM_SLAVES_4);

`ifdef AW_DECERR_EN
  assign decerr_aw = !mapped;
  assign tgt_sel   = sel;
`else
  assign decerr_aw = 1'b0;
  assign tgt_sel   = mapped ? sel : LAST_SEL;
`endif

  // Next state and all channel outputs. IDLE outputs are additionally gated
  // by rst_n. Without this gate, a ready slave would show through to
  // m_awready while reset is held.
  always_comb begin
    state_nxt = state;
    m_awready = 1'b0;
    s_awvalid = '0;
    s_bready  = '0;
    m_bvalid  = 1'b0;
    m_bresp   = 2'b00;
    w_open    = 1'b0;
    w_sink    = 1'b0;
    aw_hs     = 1'b0;
    w_beat    = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n) begin
          if (decerr_aw) begin
            m_awready = 1'b1;
          end else begin
            for (int i = 0; i < num_slaves; i++) begin
              if (3'(i) == tgt_sel) begin
                m_awready    = s_awready[i];
                s_awvalid[i] = m_awvalid;
              end
            end
          end
          aw_hs = m_awvalid & m_awready;
          if (aw_hs) state_nxt = WDATA;
        end
      end
      WDATA: begin
        w_open = 1'b1;
        w_sink = decerr_q;
        w_beat = m_wvalid & m_wready;
        if (w_beat && m_wlast) state_nxt = BRESP;
      end
      BRESP: begin
        if (decerr_q) begin
          m_bvalid = 1'b1;
          m_bresp  = 2'b11;
        end else begin
          for (int i = 0; i < num_slaves; i++) begin
            if (3'(i) == aw_sel_q) begin
              m_bvalid    = s_bvalid[i];
              m_bresp     = s_bresp[i*2 +: 2];
              s_bready[i] = m_bready;
            end
          end
        end
        if (m_bvalid && m_bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      aw_sel_q  <= 3'd0;
      beat_cnt  <= 8'd0;
      awlen_q   <= 8'd0;
      decerr_q  <= 1'b0;
      wlast_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      wlast_err <= 1'b0;
      if (aw_hs) begin
        aw_sel_q <= decerr_aw ? DECERR_SEL : tgt_sel;
        awlen_q  <= m_awlen;
        beat_cnt <= 8'd0;
        decerr_q <= decerr_aw;
      end
      if (w_beat) begin
        beat_cnt <= beat_cnt + 8'd1;
        // beat_cnt is the index of the current beat. The expected last beat
        // has index awlen_q. The state machine follows m_wlast regardless.
        if (m_wlast && (beat_cnt != awlen_q)) wlast_err <= 1'b1;
        if (!m_wlast && (beat_cnt == awlen_q)) wlast_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aw_tracker.sv
// -----------------------------------------------------------------------------
// tb_aw_tracker
//
// Directed-vector bench for aw_tracker with default parameters (5 slaves,
// select field at bits 30:28). Driver tasks push the expected AW routing,
// B response and wlast_err events into queues. Negedge monitors pop and
// compare whenever the DUT presents a handshake or a pulse.
// -----------------------------------------------------------------------------
module tb_aw_tracker;
  localparam int NS = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [31:0]     m_awaddr;
  logic [7:0]      m_awlen;
  logic            m_awvalid;
  logic            m_awready;
  logic [NS*32-1:0] s_awaddr;
  logic [NS*8-1:0] s_awlen;
  logic [NS-1:0]   s_awvalid;
  logic [NS-1:0]   s_awready;
  logic            m_wvalid, m_wready, m_wlast;
  logic            w_open, w_sink;
  logic [2:0]      aw_sel_q;
  logic [NS-1:0]   s_bvalid;
  logic [NS*2-1:0] s_bresp;
  logic [NS-1:0]   s_bready;
  logic            m_bvalid;
  logic [1:0]      m_bresp;
  logic            m_bready;
  logic            wlast_err;

  aw_tracker #(.num_slaves(NS), .SEL_LSB(28)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast),
    .w_open(w_open), .w_sink(w_sink), .aw_sel_q(aw_sel_q),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
    .wlast_err(wlast_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         total_cnt = 0;
  int         pass_cnt  = 0;
  logic [2:0] aw_exp_q[$];   // expected slave index per AW handshake
  logic [4:0] b_exp_q[$];    // {aw_sel_q, bresp} per B handshake
  logic [2:0] err_exp_q[$];  // aw_sel_q expected at each wlast_err pulse
  int         mon_idx;
  logic [2:0] aw_e;
  logic [4:0] b_e;
  logic [2:0] err_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic note_fail(input string name);
    total_cnt++;
    $display("FAIL %s: event seen with no expectation queued", name);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst_n && ((s_awvalid & s_awready) != '0)) begin
      mon_idx = 0;
      for (int i = 0; i < NS; i++) if (s_awvalid[i]) mon_idx = i;
      if (aw_exp_q.size() == 0) note_fail("aw_route");
      else begin
        aw_e = aw_exp_q.pop_front();
        check("aw_route", 32'(mon_idx), 32'(aw_e));
        check("aw_addr_bcast", s_awaddr[mon_idx*32 +: 32], m_awaddr);
      end
    end
    if (m_bvalid && m_bready) begin
      if (b_exp_q.size() == 0) note_fail("b_resp");
      else begin
        b_e = b_exp_q.pop_front();
        check("b_resp", 32'(m_bresp), 32'(b_e[1:0]));
        check("b_sel", 32'(aw_sel_q), 32'(b_e[4:2]));
      end
    end
    if (wlast_err) begin
      if (err_exp_q.size() == 0) note_fail("wlast_err");
      else begin
        err_e = err_exp_q.pop_front();
        check("wlast_err_sel", 32'(aw_sel_q), 32'(err_e));
      end
    end
  end

  // ---------------- driver tasks (each ends #1 after a rising edge) ----------
  task automatic do_aw(input logic [31:0] addr, input logic [7:0] len,
                       input logic [4:0] exp_onehot, input logic [2:0] exp_sel);
    if (exp_onehot != 5'b0) aw_exp_q.push_back(exp_sel);
    m_awaddr  = addr;
    m_awlen   = len;
    m_awvalid = 1'b1;
    @(negedge clk);
    check("aw_ready", 32'(m_awready), 32'd1);
    check("aw_onehot", 32'(s_awvalid), 32'(exp_onehot));
    @(posedge clk); #1;
    m_awvalid = 1'b0;
    check("aw_sel_q", 32'(aw_sel_q), 32'(exp_sel));
  endtask

  task automatic do_w(input int nbeats, input int last_idx, input logic exp_sink);
    for (int b = 0; b < nbeats; b++) begin
      m_wvalid = 1'b1;
      m_wready = 1'b1;
      m_wlast  = (b == last_idx);
      @(negedge clk);
      check("w_open", 32'(w_open), 32'd1);
      check("w_sink", 32'(w_sink), 32'(exp_sink));
      @(posedge clk); #1;
    end
    m_wvalid = 1'b0;
    m_wready = 1'b0;
    m_wlast  = 1'b0;
  endtask

  task automatic do_b(input int sel, input logic [1:0] resp, input int stall,
                      input logic drive_slave, input logic [4:0] exp_tag);
    b_exp_q.push_back(exp_tag);
    if (drive_slave) begin
      s_bvalid[sel]         = 1'b1;
      s_bresp[sel*2 +: 2]   = resp;
    end
    m_bready = 1'b0;
    for (int c = 0; c < stall; c++) begin
      @(negedge clk);
      check("b_stall_valid", 32'(m_bvalid), 32'd1);
      check("aw_blocked", 32'(m_awready), 32'd0);
      @(posedge clk); #1;
    end
    m_bready = 1'b1;
    @(negedge clk);
    check("s_bready", 32'(s_bready), drive_slave ? 32'(5'b1 << sel) : 32'd0);
    @(posedge clk); #1;
    m_bready = 1'b0;
    s_bvalid = '0;
    s_bresp  = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_awaddr  = 32'h1000_0000;
    m_awlen   = 8'd0;
    m_awvalid = 1'b1;   // held high during reset: m_awready must still be 0
    s_awready = '1;
    m_wvalid  = 1'b0;
    m_wready  = 1'b0;
    m_wlast   = 1'b0;
    s_bvalid  = '0;
    s_bresp   = '0;
    m_bready  = 1'b0;

    // Reset state
    #2;
    check("rst_awready", 32'(m_awready), 32'd0);
    check("rst_awvalid", 32'(s_awvalid), 32'd0);
    check("rst_sel", 32'(aw_sel_q), 32'd0);
    check("rst_w_open", 32'(w_open), 32'd0);
    check("rst_bvalid", 32'(m_bvalid), 32'd0);
    check("rst_wlast_err", 32'(wlast_err), 32'd0);
    m_awvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic write to slave 2, len 3, first edge after reset
    do_aw(32'h2000_0000, 8'd3, 5'b00100, 3'd2);
    do_w(4, 3, 1'b0);
    do_b(2, 2'b00, 0, 1'b1, {3'd2, 2'b00});

    // Slave 1 write. A second AW is held during a 5-cycle B stall and
    // must be taken right after the B handshake.
    do_aw(32'h1000_0040, 8'd0, 5'b00010, 3'd1);
    do_w(1, 0, 1'b0);
    m_awaddr  = 32'h3000_0000;
    m_awlen   = 8'd1;
    m_awvalid = 1'b1;
    do_b(1, 2'b01, 5, 1'b1, {3'd1, 2'b01});
    do_aw(32'h3000_0000, 8'd1, 5'b01000, 3'd3);
    do_w(2, 1, 1'b0);
    do_b(3, 2'b10, 0, 1'b1, {3'd3, 2'b10});

    // Early wlast: len 3, wlast on the third beat
    do_aw(32'h0000_1000, 8'd3, 5'b00001, 3'd0);
    err_exp_q.push_back(3'd0);
    do_w(3, 2, 1'b0);
    do_b(0, 2'b00, 0, 1'b1, {3'd0, 2'b00});

    // Late wlast: len 0, wlast on the second beat -> two error pulses
    do_aw(32'h4000_0010, 8'd0, 5'b10000, 3'd4);
    err_exp_q.push_back(3'd4);
    err_exp_q.push_back(3'd4);
    do_w(2, 1, 1'b0);
    do_b(4, 2'b00, 1, 1'b1, {3'd4, 2'b00});

    // Unmapped address 0x7000_0000, len 1
`ifdef AW_DECERR_EN
    do_aw(32'h7000_0000, 8'd1, 5'b00000, 3'd5);
    do_w(2, 1, 1'b1);
    do_b(0, 2'b00, 0, 1'b0, {3'd5, 2'b11});
`else
    do_aw(32'h7000_0000, 8'd1, 5'b10000, 3'd4);
    do_w(2, 1, 1'b0);
    do_b(4, 2'b00, 0, 1'b1, {3'd4, 2'b00});
`endif

    // Reset pulsed in the middle of a burst
    do_aw(32'h2000_0100, 8'd3, 5'b00100, 3'd2);
    do_w(2, 99, 1'b0);
    m_awaddr  = 32'h1000_0000;
    m_awvalid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst_w_open", 32'(w_open), 32'd0);
    check("midrst_awready", 32'(m_awready), 32'd0);
    check("midrst_awvalid", 32'(s_awvalid), 32'd0);
    check("midrst_sel", 32'(aw_sel_q), 32'd0);
    check("midrst_bvalid", 32'(m_bvalid), 32'd0);
    check("midrst_bresp", 32'(m_bresp), 32'd0);
    check("midrst_bready", 32'(s_bready), 32'd0);
    check("midrst_w_sink", 32'(w_sink), 32'd0);
    check("midrst_wlast_err", 32'(wlast_err), 32'd0);
    m_awvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_aw(32'h1000_0000, 8'd2, 5'b00010, 3'd1);
    do_w(3, 2, 1'b0);
    do_b(1, 2'b00, 0, 1'b1, {3'd1, 2'b00});

    // Stray slave B response while IDLE is ignored
    s_bvalid[1]    = 1'b1;
    s_bresp[3:2]   = 2'b10;
    m_bready       = 1'b1;
    @(negedge clk);
    check("idle_s_bready", 32'(s_bready), 32'd0);
    check("idle_m_bvalid", 32'(m_bvalid), 32'd0);
    @(posedge clk); #1;
    s_bvalid = '0;
    s_bresp  = '0;
    m_bready = 1'b0;

    // Final report
    repeat (3) @(posedge clk);
    #1;
    check("aw_q_drained", 32'(aw_exp_q.size()), 32'd0);
    check("b_q_drained", 32'(b_exp_q.size()), 32'd0);
    check("err_q_drained", 32'(err_exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Hard time limit in case a driver stalls
  initial begin
    #100000;
    $display("FAIL timeout: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

endmodule
